current_block_loader: RTL and testbench

- Fetches the 16x16 current macroblock at block position curpos from external frame memory and writes it into the local current-block buffer for the motion-estimation datapath.
- Sits directly upstream of the ME controller. It is started when the controller enters its FillCurrent state.
- Its one-cycle currentfilled pulse lets the controller advance to process.
- Uses a req/gnt/rvalid memory read port with in-order responses and a bounded number of outstanding reads.

---
 rtl/current_block_loader.sv | 169 ++++++++++++++++
 tb/tb_current_block_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/current_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : current_block_loader
// Purpose  : Fetches the 16x16 current macroblock at block position curpos
//            from external frame memory (req/gnt/rvalid read port, in-order
//            responses, bounded outstanding reads) and writes it into the
//            local current-block buffer for the motion-estimation datapath.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            start, curpos       - load request and block position {y,x}
//            mem_req/addr/gnt    - read request channel
//            mem_rvalid/rdata    - read response channel (in order)
//            cb_we/addr/wdata    - current-block buffer write port
//            busy, currentfilled - load in progress / one-cycle done pulse
//            rsp_err             - sticky: response with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module current_block_loader #(
  parameter int FRAME_WORDS = 320,
  parameter int BLK_ROWS    = 16,
  parameter int ROW_WORDS   = 4,
  parameter int MAX_OUT     = 4,
  parameter int MEM_AW      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [13:0]       curpos,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              cb_we,
  output logic [5:0]        cb_addr,
  output logic [31:0]       cb_wdata,
  output logic              busy,
  output logic              currentfilled,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // MAX_OUT is limited to 1..7, so three bits hold the outstanding count.
  localparam int              OUT_W     = 3;
  localparam logic [OUT_W-1:0] C_MAX_OUT = OUT_W'(MAX_OUT);

  state_t             state_q, state_d;
  logic [13:0]        pos_q, pos_d;
  logic [6:0]         rq_q, rq_d;      // requests granted, 0..64
  logic [6:0]         rs_q, rs_d;      // responses written, 0..64
  logic [OUT_W-1:0]   out_q, out_d;    // reads in flight
  logic               cb_we_q, cb_we_d;
  logic [5:0]         cb_addr_q, cb_addr_d;
  logic [31:0]        cb_wdata_q, cb_wdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               active;
  logic               rsp_ok;
  logic               req;
  logic               grant;
  logic [MEM_AW-1:0]  addr_calc;

  assign active = (state_q == S_LOAD) || (state_q == S_DRAIN);

  // A response is only accepted while a load is running and something is
  // actually in flight; anything else is a stray and gets flagged.
  assign rsp_ok = mem_rvalid && active && (out_q != '0);

  // At the outstanding limit a new request may still go out when a response
  // retires a slot in the same cycle.
  assign req = (state_q == S_LOAD) && !rq_q[6] &&
               ((out_q < C_MAX_OUT) || ((out_q == C_MAX_OUT) && rsp_ok));

  assign grant = req && mem_gnt;

  // Modular arithmetic at MEM_AW bits yields exactly the low MEM_AW bits of
  // the full-width sum, which is the intended truncation for positions
  // outside the frame.
  assign addr_calc = MEM_AW'(pos_q[13:7]) * MEM_AW'(BLK_ROWS * FRAME_WORDS)
                   + MEM_AW'(pos_q[6:0])  * MEM_AW'(ROW_WORDS)
                   + MEM_AW'(rq_q[5:2])   * MEM_AW'(FRAME_WORDS)
                   + MEM_AW'(rq_q[1:0]);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    rq_d       = rq_q + 7'(grant);
    rs_d       = rs_q;
    out_d      = out_q + OUT_W'(grant) - OUT_W'(rsp_ok);
    cb_we_d    = 1'b0;
    cb_addr_d  = cb_addr_q;
    cb_wdata_d = cb_wdata_q;
    rsp_err_d  = rsp_err_q;

    if (rsp_ok) begin
      cb_we_d    = 1'b1;
      cb_addr_d  = rs_q[5:0];
      cb_wdata_d = mem_rdata;
      rs_d       = rs_q + 7'd1;
    end else if (mem_rvalid) begin
      rsp_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pos_d   = curpos;
          rq_d    = '0;
          rs_d    = '0;
          out_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rq_d[6]) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // rs_q reaches 64 in the same cycle the last buffer write is visible.
        if (rs_q[6]) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      rq_q       <= '0;
      rs_q       <= '0;
      out_q      <= '0;
      cb_we_q    <= 1'b0;
      cb_addr_q  <= '0;
      cb_wdata_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      rq_q       <= rq_d;
      rs_q       <= rs_d;
      out_q      <= out_d;
      cb_we_q    <= cb_we_d;
      cb_addr_q  <= cb_addr_d;
      cb_wdata_q <= cb_wdata_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign mem_req       = req;
  assign mem_addr      = req ? addr_calc : '0;
  assign cb_we         = cb_we_q;
  assign cb_addr       = cb_addr_q;
  assign cb_wdata      = cb_wdata_q;
  assign busy          = active;
  assign currentfilled = (state_q == S_DONE);
  assign rsp_err       = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_current_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_current_block_loader
// Purpose  : Self-checking bench for current_block_loader. A memory model
//            answers granted reads after a programmable latency; expected
//            addresses and buffer writes are queued when a load is issued and
//            popped by independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_current_block_loader;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] curpos = '0;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        cb_we;
  logic [5:0]  cb_addr;
  logic [31:0] cb_wdata;
  logic        busy;
  logic        currentfilled;
  logic        rsp_err;

  always #5 clk = ~clk;

  current_block_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .curpos        (curpos),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .cb_we         (cb_we),
    .cb_addr       (cb_addr),
    .cb_wdata      (cb_wdata),
    .busy          (busy),
    .currentfilled (currentfilled),
    .rsp_err       (rsp_err)
  );

  typedef struct { logic [5:0] a; logic [31:0] d; } cbw_t;
  typedef struct { int due; logic [31:0] d; } rsp_t;

  cbw_t        exp_cb[$];
  logic [17:0] exp_addr[$];
  rsp_t        pend[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   lat = 2;
  int   g_cnt = 0;
  int   done_cnt = 0;
  int   model_out = 0;
  bit   gnt_rand = 0;
  bit   inject_stray = 0;
  bit   prev_stall = 0;
  bit   prev_final = 0;
  logic [17:0] prev_addr = '0;
  logic [17:0] first_addr = '0;
  logic [17:0] last_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Frame word address of word i of the block at (x,y): 5120 words per block
  // row band, 4 words per block column, 320 words per pixel line.
  function automatic int blk_addr(input int x, input int y, input int i);
    return y * 5120 + x * 4 + (i / 4) * 320 + (i % 4);
  endfunction

  // Contents of the frame memory: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return {a[9:0], 4'h5, a} ^ 32'h3C3C_0000;
  endfunction

  // Memory model: drives responses and grants, checks the request channel.
  always @(negedge clk) begin : responder
    rsp_t r;
    int   out_pre;
    cyc++;
    if (reset) begin
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
      model_out  = 0;
      prev_stall = 0;
    end else begin
      out_pre    = model_out;
      mem_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r          = pend.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = r.d;
      end else if (inject_stray) begin
        mem_rvalid   = 1'b1;
        mem_rdata    = 32'hBAD0_BAD0;
        inject_stray = 0;
      end
      mem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (prev_stall) begin
        check("req_held_while_stalled", mem_req, 1'b1);
        check("addr_held_while_stalled", mem_addr, prev_addr);
      end
      if (mem_req && out_pre == MAX_OUT)
        check("req_at_limit_needs_rsp", mem_rvalid, 1'b1);
      if (mem_rvalid && out_pre > 0) model_out--;
      if (mem_req && mem_gnt) begin
        if (exp_addr.size() == 0) check("grant_unexpected", 1, 0);
        else check("grant_addr", mem_addr, exp_addr.pop_front());
        if (g_cnt == 0)  first_addr = mem_addr;
        if (g_cnt == 63) last_addr  = mem_addr;
        g_cnt++;
        r.due = cyc + lat;
        r.d   = mem_word(mem_addr);
        pend.push_back(r);
        model_out++;
        check("outstanding_limit", model_out <= MAX_OUT, 1);
      end
      prev_stall = mem_req && !mem_gnt;
      prev_addr  = mem_addr;
    end
  end

  // Buffer-side monitor.
  always @(negedge clk) begin : monitor
    cbw_t e;
    #2;
    if (currentfilled) begin
      done_cnt++;
      check("busy_low_at_done", busy, 1'b0);
      check("writes_complete_at_done", exp_cb.size(), 0);
      check("done_one_after_final_write", prev_final, 1);
    end
    if (cb_we) begin
      if (exp_cb.size() == 0) check("cb_unexpected_write", 1, 0);
      else begin
        e = exp_cb.pop_front();
        check("cb_addr", cb_addr, e.a);
        check("cb_wdata", cb_wdata, e.d);
      end
    end
    prev_final = cb_we && (cb_addr == 6'd63);
  end

  task automatic issue_load(input int x, input int y);
    logic [17:0] a;
    for (int i = 0; i < 64; i++) begin
      cbw_t e;
      a = 18'(blk_addr(x, y, i));
      exp_addr.push_back(a);
      e.a = 6'(i);
      e.d = mem_word(a);
      exp_cb.push_back(e);
    end
    g_cnt = 0;
    @(negedge clk);
    start  = 1'b1;
    curpos = {7'(y), 7'(x)};
    @(negedge clk);
    start = 1'b0;
    #3;
    check("first_req_cycle_after_start", mem_req, 1'b1);
    check("busy_during_load", busy, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("load_completes", done_cnt >= target, 1);
    repeat (5) @(negedge clk);
    check("single_done_pulse", done_cnt, target);
    #3;
    check("busy_low_after_done", busy, 1'b0);
  endtask

  task automatic wait_grants(input int target);
    int n = 0;
    while (g_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("grants_reached", g_cnt >= target, 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state.
    repeat (3) @(negedge clk);
    #3;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 18'd0);
    check("rst_cb_we", cb_we, 1'b0);
    check("rst_cb_addr", cb_addr, 6'd0);
    check("rst_cb_wdata", cb_wdata, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", currentfilled, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Block (0,0), grant always, latency 2.
    lat = 2;
    issue_load(0, 0);
    wait_done(1);
    check("t1_first_addr", first_addr, 18'd0);
    check("t1_last_addr", last_addr, 18'd4803);

    // Bottom-right block (79,44).
    issue_load(79, 44);
    wait_done(2);
    check("t2_first_addr", first_addr, 18'd225596);
    check("t2_last_addr", last_addr, 18'd230399);

    // Long latency against the outstanding limit.
    lat = 10;
    issue_load(5, 3);
    wait_done(3);
    check("t3_first_addr", first_addr, 18'd15380);
    check("t3_last_addr", last_addr, 18'd20183);

    // Random grant stalls.
    lat = 3;
    gnt_rand = 1;
    issue_load(40, 20);
    wait_done(4);
    check("t4_first_addr", first_addr, 18'd102560);
    check("t4_last_addr", last_addr, 18'd107363);
    gnt_rand = 0;

    // Second start mid-load with another position is ignored.
    lat = 4;
    issue_load(10, 5);
    wait_grants(10);
    @(negedge clk);
    start  = 1'b1;
    curpos = {7'd7, 7'd3};
    @(negedge clk);
    start = 1'b0;
    wait_done(5);
    check("t5_first_addr", first_addr, 18'd25640);
    check("t5_last_addr", last_addr, 18'd30443);
    check("t5_rsp_err_clear", rsp_err, 1'b0);

    // Reset after 20 grants, then late and stray responses.
    lat = 10;
    issue_load(2, 2);
    wait_grants(20);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    exp_addr.delete();
    exp_cb.delete();
    @(negedge clk);
    #3;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 18'd0);
    check("mid_rst_cb_we", cb_we, 1'b0);
    check("mid_rst_cb_addr", cb_addr, 6'd0);
    check("mid_rst_cb_wdata", cb_wdata, 32'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", currentfilled, 1'b0);
    reset = 1'b0;
    inject_stray = 1;
    repeat (20) @(negedge clk);
    #3;
    check("t6_rsp_err_set", rsp_err, 1'b1);
    check("t6_idle_after_abort", busy, 1'b0);
    check("t6_no_done_from_abort", done_cnt, 5);

    // Clean load afterwards; the error flag stays set.
    lat = 2;
    issue_load(1, 1);
    wait_done(6);
    check("t7_first_addr", first_addr, 18'd5124);
    check("t7_last_addr", last_addr, 18'd9927);
    check("t7_rsp_err_sticky", rsp_err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
